// File: rtl/add_mult_seq_if.sv
// Job, operand, accumulator-strobe and result signals of the add-multiply sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding system's view.
interface add_mult_seq_if #(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  parameter int LEN_W     = 8
);
  logic                      cfg_valid_i;
  logic                      cfg_ready_o;
  logic [LEN_W-1:0]          cfg_len_i;
  logic                      op_valid_i;
  logic                      op_ready_o;
  logic [0:7][IN_SIZE_0-1:0] op_0_i;
  logic [0:7][IN_SIZE_1-1:0] op_1_i;
  logic [0:7][IN_SIZE_0-1:0] arr_in_0_o;
  logic [0:7][IN_SIZE_1-1:0] arr_in_1_o;
  logic                      acc_clr_o;
  logic                      acc_en_o;
  logic                      acc_last_o;
  logic                      res_valid_o;
  logic                      res_ready_i;
  logic                      busy_o;

  modport slave (
    input  cfg_valid_i, cfg_len_i, op_valid_i, op_0_i, op_1_i, res_ready_i,
    output cfg_ready_o, op_ready_o, arr_in_0_o, arr_in_1_o,
           acc_clr_o, acc_en_o, acc_last_o, res_valid_o, busy_o
  );

  modport master (
    output cfg_valid_i, cfg_len_i, op_valid_i, op_0_i, op_1_i, res_ready_i,
    input  cfg_ready_o, op_ready_o, arr_in_0_o, arr_in_1_o,
           acc_clr_o, acc_en_o, acc_last_o, res_valid_o, busy_o
  );
endinterface

// File: rtl/add_mult_seq.sv
// Sequencer for the 8-lane add-multiply array: streams K operand beats into the array input
// registers and times the accumulator clear/enable/last strobes to the datapath latency.
module add_mult_seq #(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  parameter int LEN_W     = 8,
  parameter int DP_LAT    = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  add_mult_seq_if.slave bus
);
  localparam int TAG_D = DP_LAT + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]                state_r;
  logic [LEN_W-1:0]          rem_r;
  logic                      acc_clr_r;
  logic                      res_valid_r;
  logic [TAG_D-1:0]          tag_vld_r;
  logic [TAG_D-1:0]          tag_last_r;
  logic [0:7][IN_SIZE_0-1:0] arr_0_r;
  logic [0:7][IN_SIZE_1-1:0] arr_1_r;

  logic op_ready_s;
  logic hs_s;
  logic last_beat_s;
  logic cfg_take_s;

  assign op_ready_s  = !rst_i && (state_r == ST_STREAM) && (rem_r != '0);
  assign hs_s        = op_ready_s && bus.op_valid_i;
  assign last_beat_s = hs_s && (rem_r == LEN_W'(1));
  assign cfg_take_s  = (state_r == ST_IDLE) && bus.cfg_valid_i;

  // Job control: beat counting, clear pulse and result handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      rem_r       <= '0;
      acc_clr_r   <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      acc_clr_r <= cfg_take_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.cfg_valid_i) begin
            rem_r   <= bus.cfg_len_i;
            state_r <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // rem is only zero here for an empty job; nonempty jobs leave on their last beat
          if (rem_r == '0) begin
            state_r     <= ST_DONE;
            res_valid_r <= 1'b1;
          end else if (hs_s) begin
            rem_r <= rem_r - LEN_W'(1);
            if (last_beat_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (tag_last_r[DP_LAT]) begin
            state_r     <= ST_DONE;
            res_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.res_ready_i) begin
            state_r     <= ST_IDLE;
            res_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture and tag delay line matching the array latency
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_vld_r  <= '0;
      tag_last_r <= '0;
      arr_0_r    <= '0;
      arr_1_r    <= '0;
    end else begin
      tag_vld_r  <= (tag_vld_r << 1) | TAG_D'(hs_s);
      tag_last_r <= (tag_last_r << 1) | TAG_D'(last_beat_s);
      if (hs_s) begin
        arr_0_r <= bus.op_0_i;
        arr_1_r <= bus.op_1_i;
      end
    end
  end

  assign bus.cfg_ready_o = !rst_i && (state_r == ST_IDLE);
  assign bus.op_ready_o  = op_ready_s;
  assign bus.busy_o      = (state_r != ST_IDLE);
  assign bus.arr_in_0_o  = arr_0_r;
  assign bus.arr_in_1_o  = arr_1_r;
  assign bus.acc_clr_o   = acc_clr_r;
  assign bus.acc_en_o    = tag_vld_r[DP_LAT];
  assign bus.acc_last_o  = tag_last_r[DP_LAT];
  assign bus.res_valid_o = res_valid_r;
endmodule

// File: tb/tb_add_mult_seq.sv
// Scoreboard bench for add_mult_seq: accepted beats queue their expected accumulator-enable
// cycle and last flag, and a monitor pops and compares them as the strobes appear.
module tb_add_mult_seq;
  localparam int DP    = 2;
  localparam int LEN_W = 8;

  typedef struct packed {
    int   cyc;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t exp_q[$];
  exp_t mon_e;
  int   en_cnt = 0;
  int   last_cnt = 0;
  logic [0:7][3:0] exp_a0;
  logic [0:7][7:0] exp_a1;

  int   b2b_a = 0;
  logic b2b_on = 1'b0;
  int   n_clr0 = 0;
  int   n_last0 = 0;
  int   en_run0 = 0;
  int   last_cyc0 = 0;

  add_mult_seq_if b2 ();
  add_mult_seq_if b0 ();

  add_mult_seq #(.DP_LAT(DP)) u_dut  (.clk_i(clk), .rst_i(rst_i), .bus(b2));
  add_mult_seq #(.DP_LAT(0))  u_dut0 (.clk_i(clk), .rst_i(rst_i), .bus(b0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard side for the DP_LAT=2 instance
  always @(negedge clk) begin
    if (b2.acc_en_o || b2.acc_last_o) begin
      if (exp_q.size() == 0) begin
        check("en_unexpected", {b2.acc_en_o, b2.acc_last_o}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        check("en_cycle", cyc, mon_e.cyc);
        check("en_last", b2.acc_last_o, mon_e.last);
        check("en_with_last", b2.acc_en_o, 1'b1);
      end
      en_cnt   = en_cnt + (b2.acc_en_o ? 1 : 0);
      last_cnt = last_cnt + (b2.acc_last_o ? 1 : 0);
    end
    if (b2.acc_clr_o) check("clr_en_excl", b2.acc_en_o, 1'b0);
  end

  // Event tracker for the back-to-back DP_LAT=0 instance
  always @(negedge clk) begin
    if (b2b_on) begin
      if (b0.acc_clr_o) begin
        check("b2b_clr_cyc", cyc, b2b_a + 1 + 5 * n_clr0);
        check("b2b_clr_en_excl", b0.acc_en_o, 1'b0);
        if (n_clr0 > 0) begin
          check("b2b_en_per_job", en_run0, 2);
          check("b2b_clr_after_last", cyc > last_cyc0, 1'b1);
        end
        en_run0 = 0;
        n_clr0++;
      end
      if (b0.acc_en_o) en_run0++;
      if (b0.acc_last_o) begin
        check("b2b_last_cyc", cyc, b2b_a + 3 + 5 * n_last0);
        last_cyc0 = cyc;
        n_last0++;
      end
    end
  end

  task automatic check_rst_outputs();
    check("rst_arr0", b2.arr_in_0_o, '0);
    check("rst_arr1", b2.arr_in_1_o, '0);
    check("rst_clr", b2.acc_clr_o, 1'b0);
    check("rst_en", b2.acc_en_o, 1'b0);
    check("rst_last", b2.acc_last_o, 1'b0);
    check("rst_res", b2.res_valid_o, 1'b0);
    check("rst_cfg_ready", b2.cfg_ready_o, 1'b0);
    check("rst_op_ready", b2.op_ready_o, 1'b0);
    check("rst_busy", b2.busy_o, 1'b0);
  endtask

  task automatic reset_mid_job();
    rst_i = 1'b1;
    b2.op_valid_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    exp_a0 = '0;
    exp_a1 = '0;
    check_rst_outputs();
    @(posedge clk); #1;
    rst_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("post_rst_no_en", b2.acc_en_o, 1'b0);
      check("post_rst_no_res", b2.res_valid_o, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_job(input int k, input logic [15:0] pat, input int hold,
                         input logic cfg_hold, input int rst_after);
    int t_acc, t_last, t_res, sent, seen, en0, last0, i;
    logic v;
    logic [0:7][3:0] d0;
    logic [0:7][7:0] d1;
    exp_t e;
    b2.cfg_valid_i = 1'b1;
    b2.cfg_len_i   = k[LEN_W-1:0];
    @(negedge clk);
    check("cfg_accept", b2.cfg_ready_o, 1'b1);
    t_acc = cyc; en0 = en_cnt; last0 = last_cnt;
    sent = 0; i = 0; t_last = t_acc;
    @(posedge clk); #1;
    b2.cfg_valid_i = 1'b0;
    b2.cfg_len_i   = 8'($urandom());
    do begin
      v  = (i < 16) ? pat[i] : 1'b1;
      d0 = $urandom();
      d1 = {$urandom(), $urandom()};
      if (v) d0[0] = 4'(sent + 1);
      b2.op_valid_i = v;
      b2.op_0_i = d0;
      b2.op_1_i = d1;
      @(negedge clk);
      check("clr", b2.acc_clr_o, i == 0);
      check("op_ready", b2.op_ready_o, sent < k);
      check("arr0", b2.arr_in_0_o, exp_a0);
      check("arr1", b2.arr_in_1_o, exp_a1);
      if (v && sent < k) begin
        e.cyc = cyc + 1 + DP;
        e.last = (sent == k - 1);
        exp_q.push_back(e);
        exp_a0 = d0;
        exp_a1 = d1;
        sent++;
        t_last = cyc;
      end
      i++;
      @(posedge clk); #1;
      if (rst_after != 0 && sent == rst_after) begin
        reset_mid_job();
        return;
      end
    end while (sent < k);

    b2.op_valid_i  = 1'b0;
    b2.op_0_i      = $urandom();
    b2.cfg_valid_i = cfg_hold;
    t_res = (k == 0) ? t_acc + 2 : t_last + DP + 2;
    seen = 0;
    for (int w = 0; w < 64 && seen == 0; w++) begin
      @(negedge clk);
      check("arr0_hold", b2.arr_in_0_o, exp_a0);
      if (b2.res_valid_o) begin
        seen = cyc;
      end else begin
        check("op_ready_drain", b2.op_ready_o, 1'b0);
        check("cfg_ready_busy", b2.cfg_ready_o, 1'b0);
      end
      @(posedge clk); #1;
    end
    check("res_cycle", seen, t_res);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("res_hold", b2.res_valid_o, 1'b1);
      check("cfg_ready_done", b2.cfg_ready_o, 1'b0);
      @(posedge clk); #1;
    end
    b2.res_ready_i = 1'b1;
    @(negedge clk);
    check("res_at_take", b2.res_valid_o, 1'b1);
    check("cfg_ready_take", b2.cfg_ready_o, 1'b0);
    check("en_count", en_cnt - en0, k);
    check("last_count", last_cnt - last0, (k != 0) ? 1 : 0);
    check("sb_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    b2.res_ready_i = 1'b0;
  endtask

  task automatic run_b2b();
    b2b_a  = cyc;
    b2b_on = 1'b1;
    b0.cfg_len_i   = 8'd2;
    b0.res_ready_i = 1'b1;
    b0.op_valid_i  = 1'b1;
    for (int c = 0; c < 18; c++) begin
      b0.cfg_valid_i = (c <= 5);
      b0.op_0_i = $urandom();
      b0.op_1_i = {$urandom(), $urandom()};
      @(negedge clk);
      @(posedge clk); #1;
    end
    b0.op_valid_i  = 1'b0;
    b0.cfg_valid_i = 1'b0;
    @(negedge clk);
    check("b2b_clr_count", n_clr0, 2);
    check("b2b_last_count", n_last0, 2);
    check("b2b_en_job2", en_run0, 2);
    check("b2b_idle", b0.busy_o, 1'b0);
    b2b_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    b2.cfg_valid_i = 1'b0; b2.cfg_len_i = '0; b2.op_valid_i = 1'b0;
    b2.op_0_i = '0; b2.op_1_i = '0; b2.res_ready_i = 1'b0;
    b0.cfg_valid_i = 1'b0; b0.cfg_len_i = '0; b0.op_valid_i = 1'b0;
    b0.op_0_i = '0; b0.op_1_i = '0; b0.res_ready_i = 1'b0;
    exp_a0 = '0;
    exp_a1 = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_rst_outputs();
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_cfg_ready", b2.cfg_ready_o, 1'b1);
    check("idle_busy", b2.busy_o, 1'b0);
    @(posedge clk); #1;

    run_job(3, 16'hFFFF, 0, 1'b0, 0);
    run_job(4, 16'b1111_1111_1101_1001, 0, 1'b0, 0);
    run_job(0, 16'hFFFF, 3, 1'b0, 0);
    run_job(2, 16'hFFFF, 5, 1'b1, 0);
    run_job(1, 16'hFFFF, 0, 1'b0, 0);
    run_job(5, 16'hFFFF, 0, 1'b0, 2);
    run_job(1, 16'hFFFF, 0, 1'b0, 0);
    run_job(6, 16'b1111_1111_1010_0110, 1, 1'b0, 0);
    run_b2b();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
